// File: rtl/param_yavas_sayac_pkg.sv
// Shared encodings for the slow step counter: overflow mode and count direction.
package sayac_pkg;

  localparam logic MOD_DOYUM  = 1'b0;
  localparam logic MOD_SARMA  = 1'b1;
  localparam logic YON_ASAGI  = 1'b0;
  localparam logic YON_YUKARI = 1'b1;

  typedef struct packed {
    logic ust_sinir;
    logic alt_sinir;
    logic tasma;
  } durum_t;

endpackage

// File: rtl/param_yavas_sayac_if.sv
// Control/status bundle of the slow step counter; the user side is master.
interface param_yavas_sayac_if #(
  parameter int WIDTH  = 6,
  parameter int STEP_W = 3
);
  logic              etkin;
  logic              sayma_yonu;
  logic [STEP_W-1:0] sayma_miktari;
  logic              tasma_modu;
  logic [WIDTH-1:0]  ust_limit;
  logic              yukle;
  logic [WIDTH-1:0]  yukle_deger;
  logic [WIDTH-1:0]  sayac_out;
  logic              tik;
  logic              ust_sinir;
  logic              alt_sinir;
  logic              tasma;

  modport master (
    output etkin, sayma_yonu, sayma_miktari, tasma_modu, ust_limit, yukle, yukle_deger,
    input  sayac_out, tik, ust_sinir, alt_sinir, tasma
  );

  modport slave (
    input  etkin, sayma_yonu, sayma_miktari, tasma_modu, ust_limit, yukle, yukle_deger,
    output sayac_out, tik, ust_sinir, alt_sinir, tasma
  );
endinterface

// File: rtl/param_yavas_sayac_tik_uretici.sv
// Prescaler: one tik_en per DIV enabled clocks; temizle restarts the period.
module tik_uretici #(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic sifirlama,
  input  logic etkin,
  input  logic temizle,
  output logic tik_en
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] SON = PW'(DIV - 1);

  logic [PW-1:0] bolen_q;

  // A clear on the same edge wins, so no tick leaks out of a load cycle.
  assign tik_en = etkin && !temizle && (bolen_q == SON);

  always_ff @(posedge clk or posedge sifirlama) begin
    if (sifirlama) begin
      bolen_q <= '0;
    end else if (temizle || tik_en) begin
      bolen_q <= '0;
    end else if (etkin) begin
      bolen_q <= bolen_q + PW'(1);
    end
  end
endmodule

// File: rtl/param_yavas_sayac.sv
// Slow up/down step counter with programmable limit, saturate/wrap modes and status strobes.
module param_yavas_sayac
  import sayac_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int STEP_W = 3,
  parameter int DIV    = 5
) (
  input  logic clk,
  input  logic sifirlama,
  param_yavas_sayac_if.slave bus
);
  localparam int AW = WIDTH + 1;

  logic             tik_en;
  logic [WIDTH-1:0] sayac_q;
  logic             tik_q;
  durum_t           durum_q;

  logic [AW-1:0]    c, m, lim, lim1, toplam;
  logic             sarma_gecerli;
  logic [WIDTH-1:0] sonuc;
  durum_t           durum_d;
  logic [WIDTH-1:0] yukle_sonuc;

  tik_uretici #(.DIV(DIV)) u_tik_uretici (
    .clk       (clk),
    .sifirlama (sifirlama),
    .etkin     (bus.etkin),
    .temizle   (bus.yukle),
    .tik_en    (tik_en)
  );

  always_comb begin
    c      = {1'b0, sayac_q};
    m      = AW'(bus.sayma_miktari);
    lim    = {1'b0, bus.ust_limit};
    lim1   = lim + AW'(1);
    toplam = c + m;
    // Steps larger than the modulus cannot wrap meaningfully; they clamp instead.
    sarma_gecerli = (bus.tasma_modu == MOD_SARMA) && (m <= lim1);
    sonuc   = sayac_q;
    durum_d = '0;

    if (c > lim) begin
      sonuc             = bus.ust_limit;
      durum_d.ust_sinir = 1'b1;
    end else if (bus.sayma_yonu == YON_YUKARI) begin
      if (toplam > lim) begin
        if (sarma_gecerli) begin
          sonuc         = WIDTH'(toplam - lim1);
          durum_d.tasma = 1'b1;
        end else begin
          sonuc             = bus.ust_limit;
          durum_d.ust_sinir = 1'b1;
        end
      end else begin
        sonuc = WIDTH'(toplam);
      end
    end else begin
      if (m > c) begin
        if (sarma_gecerli) begin
          sonuc         = WIDTH'(c + lim1 - m);
          durum_d.tasma = 1'b1;
        end else begin
          sonuc             = '0;
          durum_d.alt_sinir = 1'b1;
        end
      end else begin
        sonuc = WIDTH'(c - m);
      end
    end

    yukle_sonuc = (bus.yukle_deger > bus.ust_limit) ? bus.ust_limit : bus.yukle_deger;
  end

  always_ff @(posedge clk or posedge sifirlama) begin
    if (sifirlama) begin
      sayac_q <= '0;
      tik_q   <= 1'b0;
      durum_q <= '0;
    end else begin
      tik_q   <= 1'b0;
      durum_q <= '0;
      if (bus.yukle) begin
        sayac_q <= yukle_sonuc;
      end else if (tik_en) begin
        sayac_q <= sonuc;
        tik_q   <= 1'b1;
        durum_q <= durum_d;
      end
    end
  end

  assign bus.sayac_out = sayac_q;
  assign bus.tik       = tik_q;
  assign bus.ust_sinir = durum_q.ust_sinir;
  assign bus.alt_sinir = durum_q.alt_sinir;
  assign bus.tasma     = durum_q.tasma;
endmodule

// File: tb/tb_param_yavas_sayac.sv
// Bench for param_yavas_sayac: vector table plus hand sequences, tick results checked via scoreboard.
module tb_param_yavas_sayac;
  import sayac_pkg::*;

  localparam int WIDTH  = 6;
  localparam int STEP_W = 3;
  localparam int DIV    = 5;

  typedef struct {
    logic [5:0] lim_load;
    logic [5:0] start;
    logic [5:0] lim;
    logic       mod;
    logic       yon;
    logic [2:0] m;
    logic [5:0] e_cnt;
    logic [2:0] e_flg;
  } vec_t;

  typedef struct {
    logic [5:0] cnt;
    logic [2:0] flg;
  } exp_t;

  logic clk = 1'b0;
  logic sifirlama;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[17];

  param_yavas_sayac_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  param_yavas_sayac #(.WIDTH(WIDTH), .STEP_W(STEP_W), .DIV(DIV)) dut (
    .clk       (clk),
    .sifirlama (sifirlama),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int ll, int st, int l, int md, int yn, int mm, int ec, int ef);
    vec_t r;
    r.lim_load = 6'(ll);
    r.start    = 6'(st);
    r.lim      = 6'(l);
    r.mod      = 1'(md);
    r.yon      = 1'(yn);
    r.m        = 3'(mm);
    r.e_cnt    = 6'(ec);
    r.e_flg    = 3'(ef);
    return r;
  endfunction

  function automatic exp_t ex(int cnt, int flg);
    exp_t e;
    e.cnt = 6'(cnt);
    e.flg = 3'(flg);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL tick_timeout: %0d results still pending after %0d cycles", sb.size(), bound);
      sb.delete();
    end
  endtask

  task automatic load(input logic [5:0] val, input logic [5:0] lim);
    bus.ust_limit   = lim;
    bus.yukle_deger = val;
    bus.yukle       = 1'b1;
    bus.etkin       = 1'b0;
    step();
    bus.yukle = 1'b0;
  endtask

  // Scoreboard consumer: every tik pops one expectation; strobes outside a tik are errors.
  always @(negedge clk) begin
    if (bus.tik === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tik: got tik with count %0d, expected no tik", bus.sayac_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tick_count", 32'(bus.sayac_out), 32'(e.cnt));
        chk("tick_strobes", 32'({bus.ust_sinir, bus.alt_sinir, bus.tasma}), 32'(e.flg));
      end
    end else begin
      chk("idle_strobes", 32'({bus.ust_sinir, bus.alt_sinir, bus.tasma}), 32'(0));
    end
  end

  initial begin
    // lim_load, start, lim, mode, dir, m, expected count, expected {ust,alt,tasma}
    vecs[0]  = mk(63, 60, 63, 0, 1, 7, 63, 3'b100);
    vecs[1]  = mk(63,  3, 63, 0, 0, 5,  0, 3'b010);
    vecs[2]  = mk(63,  5, 63, 0, 0, 5,  0, 3'b000);
    vecs[3]  = mk( 9,  8,  9, 1, 1, 3,  1, 3'b001);
    vecs[4]  = mk( 9,  1,  9, 1, 0, 3,  8, 3'b001);
    vecs[5]  = mk( 3,  2,  3, 1, 1, 7,  3, 3'b100);
    vecs[6]  = mk( 3,  2,  3, 1, 0, 7,  0, 3'b010);
    vecs[7]  = mk(63, 30, 20, 0, 1, 1, 20, 3'b100);
    vecs[8]  = mk(63, 30, 20, 1, 0, 1, 20, 3'b100);
    vecs[9]  = mk(63, 10, 63, 0, 1, 5, 15, 3'b000);
    vecs[10] = mk( 9,  7,  9, 1, 0, 2,  5, 3'b000);
    vecs[11] = mk(63, 60, 63, 0, 1, 3, 63, 3'b000);
    vecs[12] = mk( 0,  0,  0, 1, 1, 1,  0, 3'b001);
    vecs[13] = mk( 0,  0,  0, 0, 1, 1,  0, 3'b100);
    vecs[14] = mk(63, 12, 63, 1, 1, 0, 12, 3'b000);
    vecs[15] = mk( 5,  2,  5, 1, 1, 6,  2, 3'b001);
    vecs[16] = mk( 5,  2,  5, 1, 0, 7,  0, 3'b010);

    sifirlama         = 1'b1;
    bus.etkin         = 1'b0;
    bus.sayma_yonu    = YON_YUKARI;
    bus.sayma_miktari = '0;
    bus.tasma_modu    = MOD_DOYUM;
    bus.ust_limit     = 6'd63;
    bus.yukle         = 1'b0;
    bus.yukle_deger   = '0;
    step();
    step();
    chk("reset_count", 32'(bus.sayac_out), 32'(0));
    chk("reset_tik", 32'(bus.tik), 32'(0));
    sifirlama = 1'b0;
    step();

    for (int i = 0; i < 17; i++) begin
      bus.tasma_modu    = vecs[i].mod;
      bus.sayma_yonu    = vecs[i].yon;
      bus.sayma_miktari = vecs[i].m;
      load(vecs[i].start, vecs[i].lim_load);
      chk("vec_load", 32'(bus.sayac_out), 32'(vecs[i].start));
      bus.ust_limit = vecs[i].lim;
      bus.etkin     = 1'b1;
      sb.push_back(ex(int'(vecs[i].e_cnt), int'(vecs[i].e_flg)));
      wait_empty(12);
      bus.etkin = 1'b0;
    end

    // Asynchronous reset mid-count, then tick timing after release
    bus.tasma_modu = MOD_DOYUM;
    bus.sayma_yonu = YON_YUKARI;
    bus.sayma_miktari = 3'd1;
    load(6'd17, 6'd63);
    bus.etkin = 1'b1;
    step();
    step();
    sifirlama = 1'b1;
    #1;
    chk("async_reset_count", 32'(bus.sayac_out), 32'(0));
    chk("async_reset_strobes", 32'({bus.tik, bus.ust_sinir, bus.alt_sinir, bus.tasma}), 32'(0));
    step();
    sifirlama = 1'b0;
    sb.push_back(ex(1, 0));
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("post_reset_tick_timing", 32'(bus.tik), 32'(i == 5));
    end
    bus.etkin = 1'b0;
    wait_empty(2);

    // Up saturate twice in a row: clamped result and a fresh strobe each tick
    bus.sayma_miktari = 3'd7;
    load(6'd60, 6'd63);
    bus.etkin = 1'b1;
    sb.push_back(ex(63, 3'b100));
    sb.push_back(ex(63, 3'b100));
    wait_empty(15);
    bus.etkin = 1'b0;

    // Load coincident with a tick edge: clamped to limit, no tick, prescaler restarts
    bus.sayma_miktari = 3'd0;
    load(6'd5, 6'd63);
    bus.etkin = 1'b1;
    repeat (4) step();
    bus.yukle_deger = 6'd50;
    bus.ust_limit   = 6'd40;
    bus.yukle       = 1'b1;
    step();
    bus.yukle = 1'b0;
    chk("load_on_tick_count", 32'(bus.sayac_out), 32'(40));
    chk("load_on_tick_tik", 32'(bus.tik), 32'(0));
    sb.push_back(ex(40, 0));
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("restart_tick_timing", 32'(bus.tik), 32'(i == 5));
    end
    bus.etkin = 1'b0;
    wait_empty(2);

    // Enable low for 12 cycles freezes both count and prescaler
    bus.sayma_miktari = 3'd1;
    load(6'd10, 6'd63);
    bus.etkin = 1'b1;
    step();
    step();
    bus.etkin = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("frozen_count", 32'(bus.sayac_out), 32'(10));
      chk("frozen_tik", 32'(bus.tik), 32'(0));
    end
    sb.push_back(ex(11, 0));
    bus.etkin = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("resume_tick_timing", 32'(bus.tik), 32'(i == 3));
    end
    bus.etkin = 1'b0;
    wait_empty(2);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
